// File: rtl/float_pkg.sv
// Shared constants and types for the float add dispatch path.
// Holds the IEEE-754 single layout, the dispatcher state type and common operand constants.
package float_pkg;

   localparam int float_width      = 32;
   localparam int float_exp_width  = 8;
   localparam int float_mant_width = 23;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } e_dispatch_state;

   localparam logic [float_width-1:0] float_pos_zero = 32'h0000_0000;
   localparam logic [float_width-1:0] float_one      = 32'h3F80_0000;

endpackage

// File: rtl/float_op_fifo.sv
// Synchronous FIFO of {a, b, tag} add requests feeding the dispatcher.
// Registered head, no fall-through; push is refused while full even if a pop happens.
module float_op_fifo
   import float_pkg::*;
#(
   parameter int data_width = float_width,
   parameter int tag_width  = 4,
   parameter int depth      = 4
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [data_width-1:0]       push_a,
   input  logic [data_width-1:0]       push_b,
   input  logic [tag_width-1:0]        push_tag,
   input  logic                        pop,
   output logic [data_width-1:0]       head_a,
   output logic [data_width-1:0]       head_b,
   output logic [tag_width-1:0]        head_tag,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(depth):0]      count
);

   localparam int addr_width  = $clog2(depth);
   localparam int count_width = addr_width + 1;
   localparam logic [count_width-1:0] full_count = count_width'(depth);

   logic [data_width-1:0]  mem_a_r   [depth];
   logic [data_width-1:0]  mem_b_r   [depth];
   logic [tag_width-1:0]   mem_tag_r [depth];
   logic [addr_width-1:0]  wr_ptr_r;
   logic [addr_width-1:0]  rd_ptr_r;
   logic [count_width-1:0] count_r;
   logic                   push_ok_s;
   logic                   pop_ok_s;

   assign full      = (count_r == full_count);
   assign empty     = (count_r == {count_width{1'b0}});
   assign count     = count_r;
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign head_a    = mem_a_r[rd_ptr_r];
   assign head_b    = mem_b_r[rd_ptr_r];
   assign head_tag  = mem_tag_r[rd_ptr_r];

   // Storage, pointers (wrapping naturally at a power-of-two depth) and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {addr_width{1'b0}};
         rd_ptr_r <= {addr_width{1'b0}};
         count_r  <= {count_width{1'b0}};
         for (int i = 0; i < depth; i++) begin
            mem_a_r[i]   <= {data_width{1'b0}};
            mem_b_r[i]   <= {data_width{1'b0}};
            mem_tag_r[i] <= {tag_width{1'b0}};
         end
      end else begin
         if (push_ok_s) begin
            mem_a_r[wr_ptr_r]   <= push_a;
            mem_b_r[wr_ptr_r]   <= push_b;
            mem_tag_r[wr_ptr_r] <= push_tag;
            wr_ptr_r            <= wr_ptr_r + addr_width'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + addr_width'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + count_width'(1);
            2'b01:   count_r <= count_r - count_width'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/float_add_dispatcher.sv
// Issue stage for float_add_pipeline: queues tagged add requests, issues them one at a time,
// returns each result with its tag, and drops a hung operation under a sticky watchdog error.
module float_add_dispatcher
   import float_pkg::*;
#(
   parameter int float_width    = float_pkg::float_width,
   parameter int tag_width      = 4,
   parameter int fifo_depth     = 4,
   parameter int timeout_cycles = 15
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [float_width-1:0] in_a,
   input  logic [float_width-1:0] in_b,
   input  logic [tag_width-1:0]   in_tag,
   output logic                   add_req,
   output logic [float_width-1:0] add_a,
   output logic [float_width-1:0] add_b,
   input  logic                   add_ack,
   input  logic [float_width-1:0] add_out,
   output logic                   out_valid,
   output logic [float_width-1:0] out_data,
   output logic [tag_width-1:0]   out_tag,
   output logic                   busy,
   output logic                   err
);

   localparam int count_width = $clog2(fifo_depth) + 1;
   localparam int timer_width = $clog2(timeout_cycles + 1);
   localparam logic [timer_width-1:0] timer_last = timer_width'(timeout_cycles - 1);

   e_dispatch_state         state_r;
   e_dispatch_state         next_state_s;
   logic [timer_width-1:0]  timer_r;
   logic [tag_width-1:0]    tag_r;
   logic                    add_req_r;
   logic [float_width-1:0]  add_a_r;
   logic [float_width-1:0]  add_b_r;
   logic                    out_valid_r;
   logic [float_width-1:0]  out_data_r;
   logic [tag_width-1:0]    out_tag_r;
   logic                    err_r;

   logic                    push_s;
   logic                    pop_s;
   logic                    deliver_s;
   logic                    timeout_s;
   logic [float_width-1:0]  head_a_s;
   logic [float_width-1:0]  head_b_s;
   logic [tag_width-1:0]    head_tag_s;
   logic                    fifo_full_s;
   logic                    fifo_empty_s;
   logic [count_width-1:0]  fifo_count_s;

   assign in_ready  = !fifo_full_s;
   assign push_s    = in_valid && !fifo_full_s;
   assign busy      = (fifo_count_s != {count_width{1'b0}}) || (state_r != IDLE);
   assign add_req   = add_req_r;
   assign add_a     = add_a_r;
   assign add_b     = add_b_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_tag   = out_tag_r;
   assign err       = err_r;

   float_op_fifo #(
      .data_width (float_width),
      .tag_width  (tag_width),
      .depth      (fifo_depth)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_s),
      .push_a   (in_a),
      .push_b   (in_b),
      .push_tag (in_tag),
      .pop      (pop_s),
      .head_a   (head_a_s),
      .head_b   (head_b_s),
      .head_tag (head_tag_s),
      .full     (fifo_full_s),
      .empty    (fifo_empty_s),
      .count    (fifo_count_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state: an ack always beats the watchdog terminal count in the same cycle
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s) next_state_s = WAIT;
            else               next_state_s = IDLE;
         end
         WAIT: begin
            if (add_ack) begin
               if (!fifo_empty_s) next_state_s = WAIT;
               else               next_state_s = IDLE;
            end else if (timer_r == timer_last) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = WAIT;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Per-cycle actions: issue from the FIFO head, deliver a result, or drop on timeout
   always_comb begin
      pop_s     = 1'b0;
      deliver_s = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         IDLE: begin
            pop_s = !fifo_empty_s;
         end
         WAIT: begin
            if (add_ack) begin
               deliver_s = 1'b1;
               pop_s     = !fifo_empty_s;
            end else if (timer_r == timer_last) begin
               timeout_s = 1'b1;
            end else begin
               timeout_s = 1'b0;
            end
         end
         default: begin
            pop_s     = 1'b0;
            deliver_s = 1'b0;
            timeout_s = 1'b0;
         end
      endcase
   end

   // Registered adder interface, result strobe, watchdog timer and sticky error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         add_req_r   <= 1'b0;
         add_a_r     <= {float_width{1'b0}};
         add_b_r     <= {float_width{1'b0}};
         tag_r       <= {tag_width{1'b0}};
         timer_r     <= {timer_width{1'b0}};
         out_valid_r <= 1'b0;
         out_data_r  <= {float_width{1'b0}};
         out_tag_r   <= {tag_width{1'b0}};
         err_r       <= 1'b0;
      end else begin
         add_req_r   <= pop_s;
         out_valid_r <= deliver_s;
         if (pop_s) begin
            add_a_r <= head_a_s;
            add_b_r <= head_b_s;
            tag_r   <= head_tag_s;
            timer_r <= {timer_width{1'b0}};
         end else if ((state_r == WAIT) && !add_ack) begin
            timer_r <= timer_r + timer_width'(1);
         end
         if (deliver_s) begin
            out_data_r <= add_out;
            out_tag_r  <= tag_r;
         end
         if (timeout_s) begin
            err_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_float_add_dispatcher.sv
// Self-checking bench for float_add_dispatcher: a stub adder with programmable ack latency,
// a queue-based reference of accepted operations, table vectors and directed corner sequences.
module tb_float_add_dispatcher;
   import float_pkg::*;

   localparam int fw    = 32;
   localparam int tw    = 4;
   localparam int depth = 4;
   localparam int tmo   = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid, in_ready, add_req, add_ack, out_valid, busy, err;
   logic [fw-1:0] in_a, in_b, add_a, add_b, add_out, out_data;
   logic [tw-1:0] in_tag, out_tag;

   always #5 clk = ~clk;

   float_add_dispatcher #(
      .float_width(fw), .tag_width(tw), .fifo_depth(depth), .timeout_cycles(tmo)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .add_req(add_req), .add_a(add_a), .add_b(add_b),
      .add_ack(add_ack), .add_out(add_out),
      .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
      .busy(busy), .err(err)
   );

   typedef struct {
      logic [fw-1:0] data;
      logic [tw-1:0] tag;
   } res_t;

   typedef struct {
      logic [fw-1:0] a;
      logic [fw-1:0] b;
      logic [tw-1:0] tag;
      logic [fw-1:0] exp;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   ov_count = 0;
   int   req_count = 0;
   int   req_cyc = 0;
   res_t exp_q[$];
   res_t got_q[$];
   int   ov_cyc[$];
   res_t mon_e;

   int   stub_cnt = 0;
   int   stub_lat = 3;
   bit   stub_never = 1'b0;
   bit   stub_rand = 1'b0;
   logic [fw-1:0] stub_res = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Exact sums for the operands used in directed vectors; other pairs get a scrambled stand-in.
   function automatic logic [fw-1:0] fadd_ref(input logic [fw-1:0] a, input logic [fw-1:0] b);
      logic [63:0] k;
      k = {a, b};
      case (k)
         64'h3F800000_40000000: return 32'h40400000;
         64'h3FC00000_BFC00000: return 32'h00000000;
         64'h40000000_40000000: return 32'h40800000;
         64'h3F800000_3F000000: return 32'h3FC00000;
         64'h00000000_00000000: return 32'h00000000;
         default:               return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_5A5A;
      endcase
   endfunction

   // Stub adder: ack arrives a programmable number of cycles after the request
   initial begin
      add_ack = 1'b0;
      add_out = 32'h0;
      forever begin
         @(negedge clk);
         add_ack = 1'b0;
         if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0 && !stub_never) begin
               add_ack = 1'b1;
               add_out = stub_res;
            end
         end
         if (add_req) begin
            stub_cnt  = stub_rand ? int'($urandom_range(1, 6)) : stub_lat;
            stub_res  = fadd_ref(add_a, add_b);
            req_cyc   = cyc;
            req_count++;
         end
      end
   end

   // Result monitor against the in-order reference queue
   initial begin
      forever begin
         @(negedge clk);
         if (rst && out_valid) begin
            ov_count++;
            ov_cyc.push_back(cyc);
            got_q.push_back('{out_data, out_tag});
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 64'(out_tag), 64'hFFFF);
            end else begin
               mon_e = exp_q.pop_front();
               chk("model_data", 64'(out_data), 64'(mon_e.data));
               chk("model_tag", 64'(out_tag), 64'(mon_e.tag));
            end
         end
      end
   end

   task automatic push_op(input logic [fw-1:0] a, input logic [fw-1:0] b,
                          input logic [tw-1:0] tag, output int acc_c);
      bit done = 1'b0;
      bit r;
      int t = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      while (!done && t < 200) begin
         r = in_ready;
         @(negedge clk);
         t++;
         if (r) done = 1'b1;
      end
      if (done) exp_q.push_back('{fadd_ref(a, b), tag});
      else      chk("push_timeout", 64'(t), 64'd0);
      acc_c = cyc;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input int bound);
      int t = 0;
      in_valid = 1'b0;
      while (exp_q.size() > 0 && t < bound) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_sig(input int which, input int bound);
      int t = 0;
      while (!(which == 0 ? out_valid : err) && t < bound) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   vec_t tbl[6];
   int   acc[6];
   int   acc0, base, base_ov, base_req;

   initial begin
      in_valid = 1'b0;
      in_a = 32'h0;
      in_b = 32'h0;
      in_tag = 4'h0;
      tbl[0] = '{32'h3FC00000, 32'hBFC00000, 4'd0, float_pos_zero};
      tbl[1] = '{32'h40000000, 32'h40000000, 4'd1, 32'h40800000};
      tbl[2] = '{float_one,    32'h3F000000, 4'd2, 32'h3FC00000};
      tbl[3] = '{float_pos_zero, float_pos_zero, 4'd3, float_pos_zero};
      tbl[4] = '{float_one,    32'h40000000, 4'd4, 32'h40400000};
      tbl[5] = '{32'h40000000, 32'h40000000, 4'd5, 32'h40800000};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_add_req", 64'(add_req), 64'd0);
      chk("rst_add_a", 64'(add_a), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single op latency
      push_op(float_one, 32'h40000000, 4'd3, acc0);
      in_valid = 1'b0;
      chk("t1_req_e0", 64'(add_req), 64'd0);
      @(negedge clk);
      chk("t1_req_e1", 64'(add_req), 64'd1);
      chk("t1_add_a", 64'(add_a), 64'(float_one));
      chk("t1_add_b", 64'(add_b), 64'h40000000);
      chk("t1_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("t1_req_pulse", 64'(add_req), 64'd0);
      wait_sig(0, 20);
      chk("t1_latency", 64'(cyc - acc0), 64'd5);
      chk("t1_out_data", 64'(out_data), 64'h40400000);
      chk("t1_out_tag", 64'(out_tag), 64'd3);
      chk("t1_err", 64'(err), 64'd0);
      @(negedge clk);
      chk("t1_ov_pulse", 64'(out_valid), 64'd0);
      chk("t1_data_hold", 64'(out_data), 64'h40400000);
      idle(2);

      // Back-to-back table with full-FIFO boundary
      base = ov_cyc.size();
      push_op(float_one, float_one, 4'd9, acc0);
      for (int i = 0; i < 6; i++) begin
         push_op(tbl[i].a, tbl[i].b, tbl[i].tag, acc[i]);
         if (i == 3) chk("t2_full_in_ready", 64'(in_ready), 64'd0);
      end
      drain(100);
      chk("t3_out_count", 64'(ov_cyc.size() - base), 64'd7);
      if (ov_cyc.size() - base == 7) begin
         chk("t3_push_after_pop4", 64'(acc[4] - ov_cyc[base]), 64'd1);
         chk("t3_push_after_pop5", 64'(acc[5] - ov_cyc[base + 1]), 64'd1);
         for (int i = 0; i < 6; i++) begin
            chk("t2_tbl_data", 64'(got_q[base + 1 + i].data), 64'(tbl[i].exp));
            chk("t2_tbl_tag", 64'(got_q[base + 1 + i].tag), 64'(tbl[i].tag));
            chk("t2_spacing", 64'(ov_cyc[base + 1 + i] - ov_cyc[base + i]), 64'd4);
         end
      end

      // Randomized traffic with random ack latency
      stub_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         idle(int'($urandom_range(0, 3)));
         push_op($urandom, $urandom, 4'($urandom_range(0, 15)), acc0);
      end
      drain(2000);
      chk("rand_err", 64'(err), 64'd0);
      stub_rand = 1'b0;
      idle(2);

      // Timeout drops op, next op completes, err sticky
      stub_never = 1'b1;
      base_ov = ov_count;
      push_op(32'h11111111, 32'h22222222, 4'd7, acc0);
      push_op(float_one, 32'h40000000, 4'd8, acc0);
      in_valid = 1'b0;
      wait_sig(1, 40);
      chk("t4_err", 64'(err), 64'd1);
      chk("t4_err_delay", 64'(cyc - req_cyc), 64'(tmo));
      chk("t4_no_out", 64'(ov_count), 64'(base_ov));
      if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      stub_never = 1'b0;
      drain(40);
      chk("t4_next_done", 64'(ov_count), 64'(base_ov + 1));
      chk("t4_next_tag", 64'(out_tag), 64'd8);
      chk("t4_err_sticky", 64'(err), 64'd1);

      // Ack on the terminal-count cycle wins; one cycle later loses
      do_reset();
      chk("t5_err_cleared", 64'(err), 64'd0);
      stub_lat = tmo - 1;
      push_op(float_one, 32'h40000000, 4'd10, acc0);
      in_valid = 1'b0;
      wait_sig(0, 40);
      chk("t5_tie_valid", 64'(out_valid), 64'd1);
      chk("t5_tie_delay", 64'(cyc - req_cyc), 64'(tmo));
      chk("t5_tie_data", 64'(out_data), 64'h40400000);
      chk("t5_tie_err", 64'(err), 64'd0);
      stub_lat = tmo;
      base_ov = ov_count;
      push_op(32'h40000000, 32'h40000000, 4'd11, acc0);
      in_valid = 1'b0;
      wait_sig(1, 40);
      chk("t5_late_err", 64'(err), 64'd1);
      chk("t5_late_delay", 64'(cyc - req_cyc), 64'(tmo));
      if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      idle(5);
      chk("t5_late_ignored", 64'(ov_count), 64'(base_ov));
      chk("t5_late_idle", 64'(busy), 64'd0);

      // Reset in WAIT with two ops queued
      do_reset();
      stub_lat = 10;
      push_op(float_one, float_one, 4'd1, acc0);
      push_op(float_one, float_one, 4'd2, acc0);
      push_op(float_one, float_one, 4'd3, acc0);
      in_valid = 1'b0;
      chk("t6_busy_before", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      chk("t6_add_req", 64'(add_req), 64'd0);
      chk("t6_add_a", 64'(add_a), 64'd0);
      chk("t6_add_b", 64'(add_b), 64'd0);
      chk("t6_out_data", 64'(out_data), 64'd0);
      chk("t6_out_tag", 64'(out_tag), 64'd0);
      chk("t6_in_ready", 64'(in_ready), 64'd1);
      chk("t6_busy", 64'(busy), 64'd0);
      exp_q.delete();
      base_ov = ov_count;
      base_req = req_count;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle(15);
      chk("t6_no_out", 64'(ov_count), 64'(base_ov));
      chk("t6_no_reissue", 64'(req_count), 64'(base_req));
      chk("t6_idle", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
